// File: rtl/spi_cmd_if.sv
// Bundle of SPI byte-stream, register-bank and status signals shared by
// spi_cmd_ctrl (slave side) and whatever drives the SPI datapath (master side).
interface spi_cmd_if #(
  parameter int NREG_BITS = 4
);
  logic                 cs;
  logic [7:0]           rx_byte;
  logic                 rx_valid;
  logic [7:0]           tx_byte;
  logic                 wr_en;
  logic [NREG_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic [NREG_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;
  logic                 ledState;
  logic [7:0]           err_cnt;

  modport master (
    output cs, rx_byte, rx_valid, rd_data,
    input  tx_byte, wr_en, wr_addr, wr_data, rd_addr, ledState, err_cnt
  );

  modport slave (
    input  cs, rx_byte, rx_valid, rd_data,
    output tx_byte, wr_en, wr_addr, wr_data, rd_addr, ledState, err_cnt
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: turns cmd/addr/data byte frames into register
// writes, register reads, LED control and a saturating protocol-error count.
//
// state   | meaning
// IDLE    | deselected, waiting for cs=0
// CMD     | waiting for the command byte
// ADDR    | waiting for the address byte (read or write)
// WDATA   | waiting for the write data byte
// RDOUT   | read data loaded, waiting for the master's dummy byte
// DISCARD | frame finished or aborted, ignore bytes until cs=1
module spi_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int NREG_BITS      = 4
) (
  input logic       clk,
  input logic       rst,
  spi_cmd_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDOUT, DISCARD} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             is_read;
  logic             rd_load;

  logic err_inc, led_upd, led_val, wr_fire, addr_latch, rd_latch;
  logic flag_set, flag_rd, counting, timed_out;

  assign counting  = (state == ADDR) || (state == WDATA) || (state == RDOUT);
  assign timed_out = counting && (cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_inc    = 1'b0;
    led_upd    = 1'b0;
    led_val    = 1'b1;
    wr_fire    = 1'b0;
    addr_latch = 1'b0;
    rd_latch   = 1'b0;
    flag_set   = 1'b0;
    flag_rd    = 1'b0;
    cnt_next   = (bus.rx_valid || !counting) ? '0 : cnt + CNT_W'(1);

    case (state)
      IDLE: if (!bus.cs) state_next = CMD;
      CMD: begin
        if (bus.rx_valid) begin
          case (bus.rx_byte)
            8'hA5: begin state_next = ADDR; flag_set = 1'b1; flag_rd = 1'b0; end
            8'h5A: begin state_next = ADDR; flag_set = 1'b1; flag_rd = 1'b1; end
            8'hFF: begin state_next = DISCARD; led_upd = 1'b1; led_val = 1'b0; end
            8'h01: begin state_next = DISCARD; led_upd = 1'b1; led_val = 1'b1; end
            default: begin state_next = DISCARD; err_inc = 1'b1; end
          endcase
        end
      end
      ADDR: begin
        if (timed_out) begin
          state_next = DISCARD;
          err_inc    = 1'b1;
        end else if (bus.rx_valid) begin
          if (is_read) begin
            rd_latch   = 1'b1;
            state_next = RDOUT;
          end else begin
            addr_latch = 1'b1;
            state_next = WDATA;
          end
        end
      end
      WDATA: begin
        if (timed_out) begin
          state_next = DISCARD;
          err_inc    = 1'b1;
        end else if (bus.rx_valid) begin
          wr_fire    = 1'b1;
          state_next = DISCARD;
        end
      end
      RDOUT: begin
        if (timed_out) begin
          state_next = DISCARD;
          err_inc    = 1'b1;
        end else if (bus.rx_valid) begin
          state_next = DISCARD;
        end
      end
      DISCARD: state_next = DISCARD;
      default: state_next = IDLE;
    endcase

    // Deselect overrides everything decoded this cycle; only a frame cut
    // short before its data byte counts as an error.
    if (bus.cs) begin
      state_next = IDLE;
      err_inc    = (state == ADDR) || (state == WDATA);
      led_upd    = 1'b0;
      wr_fire    = 1'b0;
      addr_latch = 1'b0;
      rd_latch   = 1'b0;
      flag_set   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      is_read      <= 1'b0;
      rd_load      <= 1'b0;
      bus.tx_byte  <= 8'h00;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 8'h00;
      bus.rd_addr  <= '0;
      bus.ledState <= 1'b1;
      bus.err_cnt  <= 8'h00;
    end else begin
      cnt       <= cnt_next;
      rd_load   <= rd_latch;
      bus.wr_en <= wr_fire;
      if (flag_set)   is_read      <= flag_rd;
      if (addr_latch) bus.wr_addr  <= bus.rx_byte[NREG_BITS-1:0];
      if (rd_latch)   bus.rd_addr  <= bus.rx_byte[NREG_BITS-1:0];
      if (rd_load)    bus.tx_byte  <= bus.rd_data;
      if (wr_fire)    bus.wr_data  <= bus.rx_byte;
      if (led_upd)    bus.ledState <= led_val;
      if (err_inc && (bus.err_cnt != 8'hFF)) bus.err_cnt <= bus.err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: byte frames driven through the interface,
// with a small external register bank answering reads and absorbing writes.
module tb_spi_cmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   wr_cycles = 0;
  logic [3:0] last_wr_addr = 4'h0;
  logic [7:0] last_wr_data = 8'h00;
  logic [7:0] regs [16];

  spi_cmd_if #(.NREG_BITS(4)) bus ();

  spi_cmd_ctrl #(.TIMEOUT_CYCLES(1000), .NREG_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rd_data = regs[bus.rd_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      regs[5] <= 8'hC3;
    end else if (bus.wr_en === 1'b1) begin
      regs[bus.wr_addr] <= bus.wr_data;
      wr_cycles    = wr_cycles + 1;
      last_wr_addr = bus.wr_addr;
      last_wr_data = bus.wr_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run time exceeded limit, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cs = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    cycle(3);
    rst = 1'b0;
    cycle(1);
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    cycle(1);
  endtask

  task automatic cs_high();
    bus.cs = 1'b1;
    cycle(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    cycle(1);
    bus.rx_valid = 1'b0;
    cycle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cs = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    cycle(3);
    checks++;
    if (bus.tx_byte !== 8'h00 || bus.wr_en !== 1'b0 || bus.wr_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got tx=%h wr_en=%b wr_data=%h required 00 0 00",
               bus.tx_byte, bus.wr_en, bus.wr_data);
    end
    checks++;
    if (bus.wr_addr !== 4'h0 || bus.rd_addr !== 4'h0) begin
      failures++;
      $display("FAIL reset_addr: got wr_addr=%h rd_addr=%h required 0 0", bus.wr_addr, bus.rd_addr);
    end
    checks++;
    if (bus.ledState !== 1'b1 || bus.err_cnt !== 8'h00 || dut.state !== 3'd0) begin
      failures++;
      $display("FAIL reset_status: got led=%b err=%0d state=%0d required 1 0 0",
               bus.ledState, bus.err_cnt, dut.state);
    end
    rst = 1'b0;
    cycle(1);
  endtask

  task automatic test_write();
    int base;
    do_reset();
    base = wr_cycles;
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h7E);
    cs_high();
    checks++;
    if (wr_cycles - base !== 1) begin
      failures++;
      $display("FAIL write_pulse: got %0d wr_en cycles required 1", wr_cycles - base);
    end
    checks++;
    if (last_wr_addr !== 4'h3 || last_wr_data !== 8'h7E) begin
      failures++;
      $display("FAIL write_value: got addr=%h data=%h required 3 7e", last_wr_addr, last_wr_data);
    end
    checks++;
    if (bus.err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL write_err: got %0d required 0", bus.err_cnt);
    end
    // upper address bits must be dropped
    cs_low();
    send_byte(8'hA5);
    send_byte(8'hF9);
    send_byte(8'h11);
    cs_high();
    checks++;
    if (wr_cycles - base !== 2 || last_wr_addr !== 4'h9 || last_wr_data !== 8'h11) begin
      failures++;
      $display("FAIL write_addr_mask: got n=%0d addr=%h data=%h required 2 9 11",
               wr_cycles - base, last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_read();
    int base;
    do_reset();
    base = wr_cycles;
    cs_low();
    send_byte(8'h5A);
    send_byte(8'h05);
    checks++;
    if (bus.tx_byte !== 8'hC3 || bus.rd_addr !== 4'h5) begin
      failures++;
      $display("FAIL read_load: got tx=%h rd_addr=%h required c3 5", bus.tx_byte, bus.rd_addr);
    end
    send_byte(8'h00);
    cs_high();
    checks++;
    if (bus.tx_byte !== 8'hC3) begin
      failures++;
      $display("FAIL read_hold: got tx=%h required c3", bus.tx_byte);
    end
    // write then read back through the bank
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h0A);
    send_byte(8'h6D);
    cs_high();
    cs_low();
    send_byte(8'h5A);
    send_byte(8'h2A);
    cs_high();
    checks++;
    if (bus.tx_byte !== 8'h6D || bus.err_cnt !== 8'h00 || wr_cycles - base !== 1) begin
      failures++;
      $display("FAIL read_back: got tx=%h err=%0d writes=%0d required 6d 0 1",
               bus.tx_byte, bus.err_cnt, wr_cycles - base);
    end
  endtask

  task automatic test_led();
    do_reset();
    cs_low();
    send_byte(8'hFF);
    send_byte(8'h01);
    cs_high();
    checks++;
    if (bus.ledState !== 1'b0) begin
      failures++;
      $display("FAIL led_on: got %b required 0", bus.ledState);
    end
    cs_low();
    send_byte(8'h01);
    cs_high();
    checks++;
    if (bus.ledState !== 1'b1) begin
      failures++;
      $display("FAIL led_off: got %b required 1", bus.ledState);
    end
    cs_low();
    send_byte(8'h3C);
    cs_high();
    checks++;
    if (bus.err_cnt !== 8'd1 || bus.ledState !== 1'b1) begin
      failures++;
      $display("FAIL led_illegal: got err=%0d led=%b required 1 1", bus.err_cnt, bus.ledState);
    end
    // deselect coincident with the command strobe wins
    cs_low();
    bus.cs = 1'b1;
    bus.rx_byte = 8'hFF;
    bus.rx_valid = 1'b1;
    cycle(1);
    bus.rx_valid = 1'b0;
    cycle(2);
    checks++;
    if (bus.ledState !== 1'b1 || bus.err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL led_cs_wins: got led=%b err=%0d required 1 1", bus.ledState, bus.err_cnt);
    end
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    base = wr_cycles;
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h02);
    cycle(999);
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL timeout_early: got err=%0d required 0", bus.err_cnt);
    end
    cycle(1);
    checks++;
    if (bus.err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL timeout_fire: got err=%0d required 1", bus.err_cnt);
    end
    send_byte(8'h55);
    cs_high();
    checks++;
    if (wr_cycles - base !== 0 || bus.err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL timeout_late_byte: got writes=%0d err=%0d required 0 1",
               wr_cycles - base, bus.err_cnt);
    end
  endtask

  task automatic test_abort();
    int base;
    do_reset();
    base = wr_cycles;
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h02);
    bus.cs = 1'b1;
    bus.rx_byte = 8'h55;
    bus.rx_valid = 1'b1;
    cycle(1);
    bus.rx_valid = 1'b0;
    checks++;
    if (dut.state !== 3'd0 || bus.err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL abort_state: got state=%0d err=%0d required 0 1", dut.state, bus.err_cnt);
    end
    cycle(2);
    checks++;
    if (wr_cycles - base !== 0) begin
      failures++;
      $display("FAIL abort_no_write: got %0d writes required 0", wr_cycles - base);
    end
    // read frame cut short after its address is not an error
    cs_low();
    send_byte(8'h5A);
    send_byte(8'h05);
    cs_high();
    checks++;
    if (bus.err_cnt !== 8'd1 || bus.tx_byte !== 8'hC3) begin
      failures++;
      $display("FAIL abort_rdout: got err=%0d tx=%h required 1 c3", bus.err_cnt, bus.tx_byte);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 255; i++) begin
      cs_low();
      send_byte(8'h3C);
      cs_high();
    end
    checks++;
    if (bus.err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_255: got %0d required 255", bus.err_cnt);
    end
    cs_low();
    send_byte(8'h77);
    cs_high();
    checks++;
    if (bus.err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_hold: got %0d required 255", bus.err_cnt);
    end
  endtask

  task automatic test_rst_midframe();
    int base;
    cs_low();
    send_byte(8'hFF);
    cs_high();
    cs_low();
    send_byte(8'h5A);
    send_byte(8'h05);
    cs_high();
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h06);
    send_byte(8'hAA);
    cs_high();
    base = wr_cycles;
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h04);
    rst = 1'b1;
    cycle(1);
    checks++;
    if (bus.tx_byte !== 8'h00 || bus.wr_data !== 8'h00 || bus.wr_addr !== 4'h0 ||
        bus.rd_addr !== 4'h0) begin
      failures++;
      $display("FAIL rst_mid_data: got tx=%h wr_data=%h wr_addr=%h rd_addr=%h required 00 00 0 0",
               bus.tx_byte, bus.wr_data, bus.wr_addr, bus.rd_addr);
    end
    checks++;
    if (bus.ledState !== 1'b1 || bus.err_cnt !== 8'h00 || dut.state !== 3'd0 ||
        bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_status: got led=%b err=%0d state=%0d wr_en=%b required 1 0 0 0",
               bus.ledState, bus.err_cnt, dut.state, bus.wr_en);
    end
    bus.cs = 1'b1;
    cycle(1);
    rst = 1'b0;
    cycle(3);
    checks++;
    if (wr_cycles - base !== 0 || bus.err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_after: got writes=%0d err=%0d required 0 0",
               wr_cycles - base, bus.err_cnt);
    end
  endtask

  initial begin
    bus.cs = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_led();
    test_timeout();
    test_abort();
    test_saturate();
    test_rst_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
